keypad_scan_debounce: RTL

//  4x4 matrix-keypad scanner and debouncer, directly upstream of the game-event FSM.

---
 rtl/keypad_scan_debounce_pkg.sv | 57 +++++
 rtl/keypad_scan_debounce_debounce.sv | 90 +++++++++
 rtl/keypad_scan_debounce.sv | 123 ++++++++++++
 3 files changed

// File: rtl/keypad_scan_debounce_pkg.sv
// Key codes, frame observation type and the (row,col) -> key code map shared by
// the keypad scanner and its debouncer.
package keypad_pkg;

    localparam logic [3:0] KEY_0     = 4'h0;
    localparam logic [3:0] KEY_1     = 4'h1;
    localparam logic [3:0] KEY_2     = 4'h2;
    localparam logic [3:0] KEY_3     = 4'h3;
    localparam logic [3:0] KEY_4     = 4'h4;
    localparam logic [3:0] KEY_5     = 4'h5;
    localparam logic [3:0] KEY_6     = 4'h6;
    localparam logic [3:0] KEY_7     = 4'h7;
    localparam logic [3:0] KEY_8     = 4'h8;
    localparam logic [3:0] KEY_9     = 4'h9;
    localparam logic [3:0] KEY_A     = 4'hA;
    localparam logic [3:0] KEY_B     = 4'hB;
    localparam logic [3:0] KEY_C     = 4'hC;
    localparam logic [3:0] KEY_D     = 4'hD;
    localparam logic [3:0] KEY_STAR  = 4'hE;
    localparam logic [3:0] KEY_SHARP = 4'hF;

    // "No key" is hit=0; code is then don't-care, so every 4-bit code stays usable.
    typedef struct packed {
        logic       hit;
        logic [3:0] code;
    } key_obs_t;

    localparam key_obs_t KEY_NONE = '{hit: 1'b0, code: KEY_0};

    function automatic logic obs_same(input key_obs_t a, input key_obs_t b);
        return (a.hit == b.hit) && (!a.hit || (a.code == b.code));
    endfunction

    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = KEY_1;
            4'b00_01: code = KEY_2;
            4'b00_10: code = KEY_3;
            4'b00_11: code = KEY_A;
            4'b01_00: code = KEY_4;
            4'b01_01: code = KEY_5;
            4'b01_10: code = KEY_6;
            4'b01_11: code = KEY_B;
            4'b10_00: code = KEY_7;
            4'b10_01: code = KEY_8;
            4'b10_10: code = KEY_9;
            4'b10_11: code = KEY_C;
            4'b11_00: code = KEY_STAR;
            4'b11_01: code = KEY_0;
            4'b11_10: code = KEY_SHARP;
            default:  code = KEY_D;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_scan_debounce_debounce.sv
// Frame-level debouncer: a candidate observation must repeat for DEBOUNCE_FRAMES
// consecutive frames before it replaces the accepted key state.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_done_i,
    input  logic       obs_hit_i,
    input  logic [3:0] obs_code_i,
    output logic [3:0] key_code_o,
    output logic       key_valid_o,
    output logic       key_press_o,
    output logic       key_star_rise_o,
    output logic       key_sharp_rise_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_FRAMES);

    key_obs_t         obs;
    key_obs_t         cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       code_q, code_d;
    logic             valid_q, valid_d;
    logic             press_q, press_d;
    logic             star_q, star_d;
    logic             sharp_q, sharp_d;

    assign obs = '{hit: obs_hit_i, code: obs_code_i};

    always_comb begin
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        valid_d = valid_q;
        press_d = 1'b0;
        star_d  = 1'b0;
        sharp_d = 1'b0;
        if (frame_done_i) begin
            if (obs_same(obs, cand_q)) begin
                // Saturate so a long hold can never wrap into a fresh acceptance.
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cand_d = obs;
                cnt_d  = CNT_W'(1);
            end
            if (cnt_d == CNT_MAX) begin
                if (cand_d.hit && (!valid_q || (cand_d.code != code_q))) begin
                    valid_d = 1'b1;
                    code_d  = cand_d.code;
                    press_d = 1'b1;
                    star_d  = (cand_d.code == KEY_STAR);
                    sharp_d = (cand_d.code == KEY_SHARP);
                end else if (!cand_d.hit && valid_q) begin
                    valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand_q  <= KEY_NONE;
            cnt_q   <= '0;
            code_q  <= KEY_0;
            valid_q <= 1'b0;
            press_q <= 1'b0;
            star_q  <= 1'b0;
            sharp_q <= 1'b0;
        end else begin
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            press_q <= press_d;
            star_q  <= star_d;
            sharp_q <= sharp_d;
        end
    end

    assign key_code_o       = code_q;
    assign key_valid_o      = valid_q;
    assign key_press_o      = press_q;
    assign key_star_rise_o  = star_q;
    assign key_sharp_rise_o = sharp_q;

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad scanner: walks the active-low column drive, synchronises the rows and
// builds one observation per scan frame for the debouncer.
module keypad_scan_debounce
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS      = 2,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_press,
    output logic       key_star_rise,
    output logic       key_sharp_rise
);

    localparam int TICK_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_TICKS - 1);

    logic [3:0]        row_s1_q, row_s2_q;
    logic [1:0]        col_q, col_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [3:0]        key_col_q;
    logic [1:0]        p1_col_q, p2_col_q;
    logic              p1_smp_q, p2_smp_q;
    logic              acc_hit_q, acc_hit_d;
    logic [3:0]        acc_code_q, acc_code_d;
    logic              row_any;
    logic [1:0]        row_idx;
    logic              frame_done;
    logic              obs_hit;
    logic [3:0]        obs_code;

    always_comb begin
        tick_d = tick_q + TICK_W'(1);
        col_d  = col_q;
        if (tick_q == TICK_LAST) begin
            tick_d = '0;
            col_d  = col_q + 2'd1;
        end
    end

    // Lowest-numbered low row wins inside a column.
    always_comb begin
        row_any = ~&row_s2_q;
        if (!row_s2_q[0])      row_idx = 2'd0;
        else if (!row_s2_q[1]) row_idx = 2'd1;
        else if (!row_s2_q[2]) row_idx = 2'd2;
        else                   row_idx = 2'd3;
    end

    // The p2_* pipeline names the column whose last-tick rows are now leaving the
    // synchroniser, so each sample is credited to the column that produced it.
    always_comb begin
        acc_hit_d  = acc_hit_q;
        acc_code_d = acc_code_q;
        frame_done = 1'b0;
        obs_hit    = acc_hit_q;
        obs_code   = acc_code_q;
        if (p2_smp_q) begin
            if (!acc_hit_q && row_any) begin
                acc_hit_d  = 1'b1;
                acc_code_d = key_lookup(row_idx, p2_col_q);
            end
            if (p2_col_q == 2'd3) begin
                frame_done = 1'b1;
                obs_hit    = acc_hit_d;
                obs_code   = acc_code_d;
                acc_hit_d  = 1'b0;
                acc_code_d = KEY_0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_s1_q   <= 4'hF;
            row_s2_q   <= 4'hF;
            col_q      <= 2'd0;
            tick_q     <= '0;
            key_col_q  <= 4'b1110;
            p1_col_q   <= 2'd0;
            p2_col_q   <= 2'd0;
            p1_smp_q   <= 1'b0;
            p2_smp_q   <= 1'b0;
            acc_hit_q  <= 1'b0;
            acc_code_q <= KEY_0;
        end else begin
            row_s1_q   <= key_row;
            row_s2_q   <= row_s1_q;
            col_q      <= col_d;
            tick_q     <= tick_d;
            key_col_q  <= ~(4'b0001 << col_d);
            p1_col_q   <= col_q;
            p2_col_q   <= p1_col_q;
            p1_smp_q   <= (tick_q == TICK_LAST);
            p2_smp_q   <= p1_smp_q;
            acc_hit_q  <= acc_hit_d;
            acc_code_q <= acc_code_d;
        end
    end

    assign key_col = key_col_q;

    keypad_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk              (clk),
        .rst              (rst),
        .frame_done_i     (frame_done),
        .obs_hit_i        (obs_hit),
        .obs_code_i       (obs_code),
        .key_code_o       (key_code),
        .key_valid_o      (key_valid),
        .key_press_o      (key_press),
        .key_star_rise_o  (key_star_rise),
        .key_sharp_rise_o (key_sharp_rise)
    );

endmodule
